// File: rtl/exception_flush_controller.sv
// Pipeline recovery sequencer: flush all stages, then redirect fetch.
// Optional interrupt source enabled by EXCEPTION_FLUSH_INTERRUPT_EN.
module exception_flush_controller #(
  parameter logic [31:0] EXCEPTION_VECTOR = 32'hBFC00380,
  parameter int          FLUSH_CYCLES     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_exception_valid,
  input  logic        wb_eret,
  input  logic [31:0] cp0_epc,
`ifdef EXCEPTION_FLUSH_INTERRUPT_EN
  input  logic        interrupt_pending,
  output logic        interrupt_ack,
`endif
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_target,
  input  logic        if_accept,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    REDIRECT
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  counter_q, counter_d;
  logic [31:0] target_q, target_d;
`ifdef EXCEPTION_FLUSH_INTERRUPT_EN
  logic        ack_q, ack_d;
`endif

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    target_d  = target_q;
`ifdef EXCEPTION_FLUSH_INTERRUPT_EN
    ack_d     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (wb_exception_valid) begin
          target_d  = EXCEPTION_VECTOR;
          counter_d = CNT_INIT;
          state_d   = FLUSH;
        end else if (wb_eret) begin
          target_d  = cp0_epc;
          counter_d = CNT_INIT;
          state_d   = FLUSH;
`ifdef EXCEPTION_FLUSH_INTERRUPT_EN
        end else if (interrupt_pending) begin
          target_d  = EXCEPTION_VECTOR;
          counter_d = CNT_INIT;
          ack_d     = 1'b1;
          state_d   = FLUSH;
`endif
        end
      end
      FLUSH: begin
        if (counter_q != 4'd0) begin
          counter_d = counter_q - 4'd1;
        end else begin
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        if (if_accept) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      counter_q <= 4'd0;
      target_q  <= 32'd0;
`ifdef EXCEPTION_FLUSH_INTERRUPT_EN
      ack_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      target_q  <= target_d;
`ifdef EXCEPTION_FLUSH_INTERRUPT_EN
      ack_q     <= ack_d;
`endif
    end
  end

  // Outputs decode from state only; no input reaches them combinationally.
  assign flush           = (state_q == FLUSH);
  assign redirect_valid  = (state_q == REDIRECT);
  assign redirect_target = redirect_valid ? target_q : 32'd0;
  assign busy            = (state_q != IDLE);
`ifdef EXCEPTION_FLUSH_INTERRUPT_EN
  assign interrupt_ack   = ack_q;
`endif

endmodule

// File: tb/tb_exception_flush_controller.sv
// Scoreboard bench for exception_flush_controller.
// Main instance uses 2 flush cycles; a second uses 4 for reset tests.
module tb_exception_flush_controller;

  localparam logic [31:0] VEC = 32'hBFC00380;

  typedef struct {
    logic [31:0] tgt;
    int          fl;
    int          rc;
    int          ack;
  } exp_t;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_n = 1'b0;
  logic        exc = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] epc = 32'd0;
  logic        acc = 1'b0;
  logic        fl, rv, bz;
  logic [31:0] rt;
`ifdef EXCEPTION_FLUSH_INTERRUPT_EN
  logic        irq = 1'b0;
  logic        ack;
  logic        irq4 = 1'b0;
  logic        ack4;
`endif

  logic        rst4 = 1'b0;
  logic        exc4 = 1'b0;
  logic        eret4 = 1'b0;
  logic [31:0] epc4 = 32'd0;
  logic        acc4 = 1'b1;
  logic        fl4, rv4, bz4;
  logic [31:0] rt4;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  int fcnt = 0;
  int rcnt = 0;
  int acks = 0;

  exception_flush_controller #(
    .EXCEPTION_VECTOR(VEC),
    .FLUSH_CYCLES(2)
  ) dut (
    .clock(clock),
    .reset(rst_n),
    .wb_exception_valid(exc),
    .wb_eret(eret),
    .cp0_epc(epc),
`ifdef EXCEPTION_FLUSH_INTERRUPT_EN
    .interrupt_pending(irq),
    .interrupt_ack(ack),
`endif
    .flush(fl),
    .redirect_valid(rv),
    .redirect_target(rt),
    .if_accept(acc),
    .busy(bz)
  );

  exception_flush_controller #(
    .EXCEPTION_VECTOR(VEC),
    .FLUSH_CYCLES(4)
  ) dut4 (
    .clock(clock),
    .reset(rst4),
    .wb_exception_valid(exc4),
    .wb_eret(eret4),
    .cp0_epc(epc4),
`ifdef EXCEPTION_FLUSH_INTERRUPT_EN
    .interrupt_pending(irq4),
    .interrupt_ack(ack4),
`endif
    .flush(fl4),
    .redirect_valid(rv4),
    .redirect_target(rt4),
    .if_accept(acc4),
    .busy(bz4)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_rv();
    int n;
    n = 0;
    while (!rv && n < 20) begin
      step();
      n++;
    end
    if (!rv) chk("rv_timeout", 32'(rv), 32'd1);
  endtask

  // Monitor: pops the expected sequence when IF takes the redirect.
  always @(negedge clock) begin
    if (rst_n) begin
      if (fl) fcnt++;
`ifdef EXCEPTION_FLUSH_INTERRUPT_EN
      if (ack) acks++;
`endif
      if (rv) begin
        rcnt++;
        if (sb.size() == 0) begin
          chk("unexpected_redirect", 32'(rv), 32'd0);
        end else begin
          chk("redir_target", rt, sb[0].tgt);
          if (acc) begin
            chk("flush_cycles", 32'(fcnt), 32'(sb[0].fl));
            chk("redir_cycles", 32'(rcnt), 32'(sb[0].rc));
            chk("ack_count", 32'(acks), 32'(sb[0].ack));
            void'(sb.pop_front());
          end
        end
        if (acc) begin
          fcnt = 0;
          rcnt = 0;
          acks = 0;
        end
      end else begin
        chk("tgt_zero_idle", rt, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=done");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    chk("rst_flush", 32'(fl), 32'd0);
    chk("rst_rv", 32'(rv), 32'd0);
    chk("rst_tgt", rt, 32'd0);
    chk("rst_busy", 32'(bz), 32'd0);
`ifdef EXCEPTION_FLUSH_INTERRUPT_EN
    chk("rst_ack", 32'(ack), 32'd0);
`endif
    rst_n = 1'b1;
    rst4  = 1'b1;
    step();

    // Exception with immediate accept: exact latency
    acc = 1'b1;
    exc = 1'b1;
    sb.push_back('{VEC, 2, 1, 0});
    step();
    exc = 1'b0;
    chk("t1_fl_c1", 32'(fl), 32'd1);
    chk("t1_bz_c1", 32'(bz), 32'd1);
    chk("t1_rv_c1", 32'(rv), 32'd0);
    step();
    chk("t1_fl_c2", 32'(fl), 32'd1);
    step();
    chk("t1_fl_c3", 32'(fl), 32'd0);
    chk("t1_rv_c3", 32'(rv), 32'd1);
    chk("t1_rt_c3", rt, VEC);
    step();
    chk("t1_bz_c4", 32'(bz), 32'd0);
    step();

    // ERET with IF stalling for 5 redirect cycles
    acc  = 1'b0;
    epc  = 32'h8000_1234;
    eret = 1'b1;
    sb.push_back('{32'h8000_1234, 2, 6, 0});
    step();
    eret = 1'b0;
    epc  = 32'hDEAD_0000;
    wait_rv();
    repeat (5) step();
    acc = 1'b1;
    step();
    chk("t2_bz_after", 32'(bz), 32'd0);
    step();

    // Exception and ERET together: exception wins, one sequence
    epc  = 32'h8000_0040;
    exc  = 1'b1;
    eret = 1'b1;
    sb.push_back('{VEC, 2, 1, 0});
    step();
    exc  = 1'b0;
    eret = 1'b0;
    repeat (6) step();
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Back-to-back: event on the accept edge dropped, next one taken
    exc = 1'b1;
    sb.push_back('{VEC, 2, 1, 0});
    step();
    exc = 1'b0;
    wait_rv();
    exc = 1'b1;
    step();
    chk("t4_dropped_bz", 32'(bz), 32'd0);
    sb.push_back('{VEC, 2, 1, 0});
    step();
    exc = 1'b0;
    chk("t4_new_bz", 32'(bz), 32'd1);
    chk("t4_new_fl", 32'(fl), 32'd1);
    repeat (6) step();

`ifdef EXCEPTION_FLUSH_INTERRUPT_EN
    // Interrupt: single ack, second request during REDIRECT ignored
    acc = 1'b0;
    irq = 1'b1;
    sb.push_back('{VEC, 2, 3, 1});
    step();
    irq = 1'b0;
    chk("t5_ack_c1", 32'(ack), 32'd1);
    chk("t5_fl_c1", 32'(fl), 32'd1);
    step();
    chk("t5_ack_c2", 32'(ack), 32'd0);
    wait_rv();
    irq = 1'b1;
    step();
    step();
    irq = 1'b0;
    acc = 1'b1;
    step();
    chk("t5_bz_after", 32'(bz), 32'd0);
    chk("t5_no_ack", 32'(ack), 32'd0);
    repeat (4) step();
`endif

    // Reset in the second flush cycle of the 4-cycle instance
    exc4 = 1'b1;
    step();
    exc4 = 1'b0;
    chk("t6_fl4_c1", 32'(fl4), 32'd1);
    step();
    chk("t6_fl4_c2", 32'(fl4), 32'd1);
    rst4 = 1'b0;
    step();
    rst4 = 1'b1;
    chk("t6_rst_fl", 32'(fl4), 32'd0);
    chk("t6_rst_bz", 32'(bz4), 32'd0);
    chk("t6_rst_rv", 32'(rv4), 32'd0);
    chk("t6_rst_rt", rt4, 32'd0);
    step();
    chk("t6_idle_bz", 32'(bz4), 32'd0);
    exc4 = 1'b1;
    step();
    exc4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t6_fl4_%0d", i), 32'(fl4), 32'd1);
      chk($sformatf("t6_rv4_%0d", i), 32'(rv4), 32'd0);
      step();
    end
    chk("t6_fl4_end", 32'(fl4), 32'd0);
    chk("t6_rv4", 32'(rv4), 32'd1);
    chk("t6_rt4", rt4, VEC);
    step();
    chk("t6_bz4_end", 32'(bz4), 32'd0);

    repeat (3) step();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
